// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch stage.
// Word/address typedefs, reset PC, fault NOP and sequencer states.
package fetch_ctrl_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam u64 PCINIT = 64'h8000_0000;
  localparam u32 NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-bus and decode-side bundles of the fetch stage.
// master = fetch_ctrl side, slave = memory / decode side.
interface fetch_ibus_if;
  import fetch_ctrl_pkg::*;

  logic ireq_valid;
  u64   ireq_addr;
  logic iresp_data_ok;
  u32   iresp_data;

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_data_ok, iresp_data
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_data_ok, iresp_data
  );
endinterface

interface fetch_dec_if;
  import fetch_ctrl_pkg::*;

  logic stall;
  logic f_valid;
  u64   f_pc;
  u32   f_instr;
  logic f_exc;

  modport master (
    input  stall,
    output f_valid, f_pc, f_instr, f_exc
  );

  modport slave (
    output stall,
    input  f_valid, f_pc, f_instr, f_exc
  );
endinterface

// File: rtl/fetch_ctrl_pcselect.sv
// Sequential-PC adder feeding the fetch next-PC mux.
// Wraps modulo 2^64.
module fetch_ctrl_pcselect
  import fetch_ctrl_pkg::*;
(
  input  u64 pc,
  output u64 pc_next
);

  assign pc_next = pc + 64'd4;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, drives the ibus,
// and holds the fetched instruction until decode takes it.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  fetch_ibus_if.master ibus,
  fetch_dec_if.master  dec,
  input  logic         trap_valid,
  input  u64           trap_pc,
  input  logic         redir_valid,
  input  u64           redir_pc
);

  fetch_state_t state_q, state_d;
  u64   pc_q, pc_d;
  u64   pend_q, pend_d;
  u32   instr_q, instr_d;
  logic exc_q, exc_d;

  u64   pc_plus4;
  u64   tgt;
  logic take;
  logic aligned;

  fetch_ctrl_pcselect u_pcselect (
    .pc      (pc_q),
    .pc_next (pc_plus4)
  );

  assign take    = trap_valid | redir_valid;
  assign tgt     = trap_valid ? trap_pc : redir_pc;
  assign aligned = (pc_q[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    instr_d = instr_q;
    exc_d   = exc_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (take) pc_d = tgt;
      end
      REQ: begin
        if (!aligned) begin
          if (take) begin
            pc_d = tgt;
          end else begin
            exc_d   = 1'b1;
            instr_d = NOP;
            state_d = HOLD;
          end
        end else if (ibus.iresp_data_ok) begin
          if (take) begin
            pc_d = tgt;
          end else begin
            instr_d = ibus.iresp_data;
            exc_d   = 1'b0;
            state_d = HOLD;
          end
        end else if (take) begin
          pend_d  = tgt;
          state_d = DISCARD;
        end
      end
      // The stale request must complete before retargeting the bus.
      DISCARD: begin
        if (ibus.iresp_data_ok) begin
          pc_d    = take ? tgt : pend_q;
          state_d = REQ;
        end else if (take) begin
          pend_d = tgt;
        end
      end
      HOLD: begin
        if (take) begin
          pc_d    = tgt;
          state_d = REQ;
        end else if (!dec.stall) begin
          pc_d    = pc_plus4;
          state_d = REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q    <= PCINIT;
      pend_q  <= '0;
      instr_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
    end
  end

  assign ibus.ireq_valid = (state_q == DISCARD) ||
                           ((state_q == REQ) && aligned);
  assign ibus.ireq_addr  = pc_q;

  assign dec.f_valid = (state_q == HOLD);
  assign dec.f_pc    = pc_q;
  assign dec.f_instr = instr_q;
  assign dec.f_exc   = exc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-cycle model compare
// plus directed literal checks over the fetch scenarios.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic trap_valid, redir_valid;
  u64   trap_pc, redir_pc;

  fetch_ibus_if ibus ();
  fetch_dec_if  dec ();

  fetch_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .ibus        (ibus),
    .dec         (dec),
    .trap_valid  (trap_valid),
    .trap_pc     (trap_pc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic u32 memword(input u64 a);
    return {a[15:0], 16'h0013};
  endfunction

  // Behavioural model: what fetch is doing, not how it is encoded
  bit m_started, m_present, m_drop, m_exc;
  u64 m_pc, m_pend, m_tgt;
  u32 m_instr;
  bit m_take;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_started = 0; m_present = 0; m_drop = 0;
      m_pc = PCINIT; m_pend = 0; m_instr = 0; m_exc = 0;
    end else begin
      m_take = trap_valid | redir_valid;
      m_tgt  = trap_valid ? trap_pc : redir_pc;
      if (!m_started) begin
        m_started = 1;
        if (m_take) m_pc = m_tgt;
      end else if (m_present) begin
        if (m_take) begin
          m_pc = m_tgt; m_present = 0;
        end else if (!dec.stall) begin
          m_pc = m_pc + 64'd4; m_present = 0;
        end
      end else if (m_drop) begin
        if (ibus.iresp_data_ok) begin
          m_pc = m_take ? m_tgt : m_pend; m_drop = 0;
        end else if (m_take) begin
          m_pend = m_tgt;
        end
      end else if (m_pc % 4 != 0) begin
        if (m_take) m_pc = m_tgt;
        else begin m_present = 1; m_instr = NOP; m_exc = 1; end
      end else if (ibus.iresp_data_ok) begin
        if (m_take) m_pc = m_tgt;
        else begin
          m_present = 1; m_instr = ibus.iresp_data; m_exc = 0;
        end
      end else if (m_take) begin
        m_pend = m_tgt; m_drop = 1;
      end
    end
  end

  bit exp_req;
  always @(negedge clk) begin
    exp_req = m_started && !m_present && (m_drop || m_pc % 4 == 0);
    chk("m ireq_valid", ibus.ireq_valid, exp_req);
    if (exp_req) chk("m ireq_addr", ibus.ireq_addr, m_pc);
    chk("m f_valid", dec.f_valid, m_present);
    chk("m f_pc", dec.f_pc, m_pc);
    if (m_present || !resetn) begin
      chk("m f_instr", dec.f_instr, m_instr);
      chk("m f_exc", dec.f_exc, m_exc);
    end
  end

  // Memory responder: answers mem_lat cycles after a request appears
  int mem_lat, mem_cnt;
  bit force_ok;

  task automatic tick();
    @(negedge clk);
    if (force_ok) begin
      ibus.iresp_data_ok = 1'b1;
      ibus.iresp_data    = 32'hDEAD_BEEF;
    end else if (ibus.ireq_valid) begin
      if (mem_cnt >= mem_lat) begin
        ibus.iresp_data_ok = 1'b1;
        ibus.iresp_data    = memword(ibus.ireq_addr);
        mem_cnt = 0;
      end else begin
        ibus.iresp_data_ok = 1'b0;
        mem_cnt++;
      end
    end else begin
      ibus.iresp_data_ok = 1'b0;
    end
  endtask

  task automatic redirect(input u64 pc);
    redir_valid = 1'b1;
    redir_pc    = pc;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ireq_valid"}, ibus.ireq_valid, 0);
    chk({tag, " f_valid"}, dec.f_valid, 0);
    chk({tag, " f_exc"}, dec.f_exc, 0);
    chk({tag, " f_instr"}, dec.f_instr, 0);
    chk({tag, " f_pc"}, dec.f_pc, 64'h8000_0000);
  endtask

  initial begin
    resetn = 0; trap_valid = 0; redir_valid = 0;
    trap_pc = 0; redir_pc = 0;
    dec.stall = 0; ibus.iresp_data_ok = 0; ibus.iresp_data = 0;
    mem_lat = 0; mem_cnt = 0; force_ok = 0;

    repeat (2) tick();
    chk_idle("rst");
    #2 resetn = 1;
    #1 chk("c0 ireq_valid", ibus.ireq_valid, 0);

    tick();
    chk("c1 ireq_valid", ibus.ireq_valid, 1);
    chk("c1 ireq_addr", ibus.ireq_addr, 64'h8000_0000);
    tick();
    chk("seq0 f_valid", dec.f_valid, 1);
    chk("seq0 f_pc", dec.f_pc, 64'h8000_0000);
    chk("seq0 f_instr", dec.f_instr, 32'h13);
    tick();
    chk("seq1 addr", ibus.ireq_addr, 64'h8000_0004);
    tick();
    chk("seq1 f_pc", dec.f_pc, 64'h8000_0004);
    dec.stall = 1;
    repeat (3) begin
      tick();
      chk("stall f_valid", dec.f_valid, 1);
      chk("stall f_pc", dec.f_pc, 64'h8000_0004);
      chk("stall f_instr", dec.f_instr, 32'h0004_0013);
      chk("stall ireq_valid", ibus.ireq_valid, 0);
    end
    dec.stall = 0;
    tick();
    chk("unstall addr", ibus.ireq_addr, 64'h8000_0008);
    tick();
    chk("seq2 f_pc", dec.f_pc, 64'h8000_0008);
    chk("seq2 f_instr", dec.f_instr, 32'h0008_0013);

    tick();
    tick();
    mem_lat = 3;
    tick();
    chk("slow addr", ibus.ireq_addr, 64'h8000_0010);
    redirect(64'h8000_0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      redir_valid = 0;
      chk("disc ireq_valid", ibus.ireq_valid, 1);
      chk("disc addr", ibus.ireq_addr, 64'h8000_0010);
      chk("disc f_valid", dec.f_valid, 0);
    end
    mem_lat = 0;
    tick();
    chk("redir addr", ibus.ireq_addr, 64'h8000_0100);
    tick();
    chk("redir f_pc", dec.f_pc, 64'h8000_0100);

    dec.stall = 1;
    trap_valid = 1; trap_pc = 64'h8000_0200;
    redirect(64'h8000_0300);
    tick();
    trap_valid = 0; redir_valid = 0; dec.stall = 0;
    chk("trap addr", ibus.ireq_addr, 64'h8000_0200);
    tick();
    chk("trap f_pc", dec.f_pc, 64'h8000_0200);

    redirect(64'h8000_0102);
    tick();
    redir_valid = 0;
    chk("mis ireq_valid", ibus.ireq_valid, 0);
    tick();
    chk("mis f_valid", dec.f_valid, 1);
    chk("mis f_exc", dec.f_exc, 1);
    chk("mis f_instr", dec.f_instr, 32'h13);
    chk("mis f_pc", dec.f_pc, 64'h8000_0102);
    tick();
    chk("mis2 ireq_valid", ibus.ireq_valid, 0);
    redirect(64'h8000_0400);
    tick();
    redir_valid = 0;
    chk("recov addr", ibus.ireq_addr, 64'h8000_0400);
    tick();
    chk("recov f_instr", dec.f_instr, 32'h0400_0013);
    chk("recov f_exc", dec.f_exc, 0);

    tick();
    redirect(64'h8000_0500);
    tick();
    redir_valid = 0;
    chk("drop addr", ibus.ireq_addr, 64'h8000_0500);
    chk("drop f_valid", dec.f_valid, 0);
    tick();

    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    redir_valid = 0;
    tick();
    chk("top f_instr", dec.f_instr, 32'hFFFC_0013);
    tick();
    chk("wrap addr", ibus.ireq_addr, 64'h0);
    tick();

    mem_lat = 5;
    tick();
    redirect(64'h8000_0600);
    tick();
    redir_valid = 0;
    chk("pre-rst addr", ibus.ireq_addr, 64'h4);
    #2 resetn = 0; mem_cnt = 0; mem_lat = 0;
    #1 chk_idle("arst");
    force_ok = 1;
    tick();
    #2 resetn = 1; force_ok = 0;
    #1 chk("late ireq_valid", ibus.ireq_valid, 0);
    tick();
    chk("restart addr", ibus.ireq_addr, 64'h8000_0000);
    tick();
    chk("restart f_pc", dec.f_pc, 64'h8000_0000);
    chk("restart f_instr", dec.f_instr, 32'h13);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
